pwm_multi_channel: RTL

Parametrised successor to the 16-output, fixed 8-bit, single-duty PWM peripheral. Drives NUM_CH output channels. Each channel has its own duty register, written through a simple register-write port from the SPI register file. The counter has a programmable period and prescaler. Duty and period updates are double-buffered and commit only at the period boundary, so no glitched pulse is ever produced. Sits between the SPI peripheral register bank and the {uio_out, uo_out} pins of the top level.

---
 rtl/pwm_multi_channel_if.sv | 30 +++
 rtl/pwm_multi_channel.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_channel_if.sv
`default_nettype none
// ============================================================================
// Module      : pwm_multi_channel_if
// Description : Register-write bus from the SPI register bank into the
//               multi-channel PWM block. One single-cycle write strobe
//               selects a channel duty shadow or the period shadow.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals:
//   wr_en    1                 single-cycle write strobe
//   wr_sel   $clog2(NUM_CH)+1  0..NUM_CH-1 = duty shadow, NUM_CH = period
//   wr_data  CNT_W             write data
// Modports:
//   master   register bank side (drives the bus)
//   slave    PWM side (receives the bus)
// ============================================================================
interface pwm_multi_channel_if #(
  parameter int NUM_CH = 16,
  parameter int CNT_W  = 8
);
  localparam int SEL_W = $clog2(NUM_CH) + 1;

  logic             wr_en;
  logic [SEL_W-1:0] wr_sel;
  logic [CNT_W-1:0] wr_data;

  modport master (output wr_en, output wr_sel, output wr_data);
  modport slave  (input  wr_en, input  wr_sel, input  wr_data);
endinterface
`default_nettype wire

// File: rtl/pwm_multi_channel.sv
`default_nettype none
// ============================================================================
// Module      : pwm_multi_channel
// Description : NUM_CH-channel PWM generator with programmable period and
//               prescaler. Duty and period writes land in shadow registers
//               and are committed to the active registers only at the period
//               wrap, so a period is never cut short or glitched.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk          in   1       system clock
//   rst          in   1       asynchronous active-high reset
//   en_out       in   NUM_CH  per-channel output enable
//   en_pwm       in   NUM_CH  per-channel PWM select (0 = static high)
//   prescale     in   PRE_W   counter advances every prescale+1 clocks
//   wr_bus       slave        shadow register write bus
//   out          out  NUM_CH  registered channel outputs
//   period_tick  out  1       one-cycle pulse following each wrap/commit
// Build option:
//   PWM_CENTER_ALIGNED_EN  when defined, the counter runs up then down and
//                          the wrap/commit point is the valley (cnt==0 while
//                          counting down). Undefined: edge-aligned up-counter.
// ============================================================================
module pwm_multi_channel #(
  parameter int NUM_CH = 16,
  parameter int CNT_W  = 8,
  parameter int PRE_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    en_out,
  input  logic [NUM_CH-1:0]    en_pwm,
  input  logic [PRE_W-1:0]     prescale,
  pwm_multi_channel_if.slave   wr_bus,
  output logic [NUM_CH-1:0]    out,
  output logic                 period_tick
);

  localparam int SEL_W = $clog2(NUM_CH) + 1;
  localparam logic [SEL_W-1:0] C_PERIOD_SEL = SEL_W'(NUM_CH);

  // Prescaler
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic             tick;

  // Period counter
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  // Shadow / active registers
  logic [NUM_CH-1:0][CNT_W-1:0] duty_shadow_q, duty_shadow_d;
  logic [NUM_CH-1:0][CNT_W-1:0] duty_active_q, duty_active_d;
  logic [CNT_W-1:0]             period_shadow_q, period_shadow_d;
  logic [CNT_W-1:0]             period_active_q, period_active_d;

  // Outputs
  logic [NUM_CH-1:0] pwm_raw;
  logic [NUM_CH-1:0] out_q, out_d;
  logic              period_tick_q, period_tick_d;

  // --------------------------------------------------------------------------
  // Prescaler. Using >= for the reload lets a prescale reduction below the
  // current count recover on the next clock without emitting a tick.
  // --------------------------------------------------------------------------
  always_comb begin
    tick      = (pre_cnt_q == prescale);
    pre_cnt_d = (pre_cnt_q >= prescale) ? '0 : pre_cnt_q + 1'b1;
  end

`ifdef PWM_CENTER_ALIGNED_EN
  // --------------------------------------------------------------------------
  // Center-aligned up/down counter. dir_q = 0 counting up, 1 counting down.
  // Leaving the valley goes straight to 1 so the 0 count is not repeated;
  // a period of 0 pins the counter at 0 and wraps every tick.
  // --------------------------------------------------------------------------
  logic dir_q, dir_d;

  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    wrap  = 1'b0;
    if (tick) begin
      if (period_active_q == '0) begin
        wrap  = 1'b1;
        dir_d = 1'b0;
        cnt_d = (period_shadow_q == '0) ? '0 : CNT_W'(1);
      end else if (!dir_q) begin
        if (cnt_q >= period_active_q) begin
          dir_d = 1'b1;
          cnt_d = cnt_q - 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (cnt_q == '0) begin
        // Valley: commit point. The next period's value decides whether the
        // counter may leave 0.
        wrap  = 1'b1;
        dir_d = 1'b0;
        cnt_d = (period_shadow_q == '0) ? '0 : CNT_W'(1);
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q <= 1'b0;
    end else begin
      dir_q <= dir_d;
    end
  end
`else
  // --------------------------------------------------------------------------
  // Edge-aligned up-counter: 0..period_active, then back to 0 (the wrap).
  // --------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    wrap  = 1'b0;
    if (tick) begin
      if (cnt_q == period_active_q) begin
        cnt_d = '0;
        wrap  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Shadow writes and commit. The commit reads the shadow _q values, so a
  // write landing on the same edge as a wrap is held for the next wrap.
  // --------------------------------------------------------------------------
  always_comb begin
    duty_shadow_d   = duty_shadow_q;
    period_shadow_d = period_shadow_q;
    if (wr_bus.wr_en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_bus.wr_sel == SEL_W'(i)) begin
          duty_shadow_d[i] = wr_bus.wr_data;
        end
      end
      if (wr_bus.wr_sel == C_PERIOD_SEL) begin
        period_shadow_d = wr_bus.wr_data;
      end
    end
    duty_active_d   = wrap ? duty_shadow_q   : duty_active_q;
    period_active_d = wrap ? period_shadow_q : period_active_q;
  end

  // --------------------------------------------------------------------------
  // Per-channel compare and output mux. Enables are live, not buffered.
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    always_comb begin
      pwm_raw[g] = (cnt_q < duty_active_q[g]);
      out_d[g]   = en_out[g] & (~en_pwm[g] | pwm_raw[g]);
    end
  end

  always_comb begin
    period_tick_d = wrap;
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q       <= '0;
      cnt_q           <= '0;
      duty_shadow_q   <= '0;
      duty_active_q   <= '0;
      period_shadow_q <= '1;
      period_active_q <= '1;
      out_q           <= '0;
      period_tick_q   <= 1'b0;
    end else begin
      pre_cnt_q       <= pre_cnt_d;
      cnt_q           <= cnt_d;
      duty_shadow_q   <= duty_shadow_d;
      duty_active_q   <= duty_active_d;
      period_shadow_q <= period_shadow_d;
      period_active_q <= period_active_d;
      out_q           <= out_d;
      period_tick_q   <= period_tick_d;
    end
  end

  assign out         = out_q;
  assign period_tick = period_tick_q;

endmodule
`default_nettype wire
